div_issue_ctrl: RTL

//  Front-end sequencer for the 8-bit shift/subtract divider datapath and its controller.

---
 rtl/div_issue_ctrl_if.sv | 41 ++++
 rtl/div_issue_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// Request, divider and response signal bundle for div_issue_ctrl.
// The controller uses the slave view; the environment driving it uses the master view.
interface div_issue_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;

    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_valid;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic [1:0]       rsp_err;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready,
        output div_start, div_dividend, div_divisor,
        input  div_valid, div_quotient, div_remainder,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready,
        input  div_start, div_dividend, div_divisor,
        output div_valid, div_quotient, div_remainder,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Request queue + one-job-in-flight sequencer in front of a shift/subtract divider.
// Pop to div_start is one cycle; a full queue drops req_ready, a stalled response blocks further issue.

module div_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module div_issue_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset,
    div_issue_ctrl_if.slave    bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0] ERR_OK = 2'b00;
    localparam logic [1:0] ERR_DZ = 2'b01;
    localparam logic [1:0] ERR_TO = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
    } req_t;

    typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    req_t             push_req;
    req_t             head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             ld_dz;
    logic             ld_div;
    logic             ld_to;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic [1:0]       rsp_e;

    assign push_req.dividend = bus.req_dividend;
    assign push_req.divisor  = bus.req_divisor;

    // Held low during reset so nothing is accepted into a queue being cleared.
    assign bus.req_ready = reset && !full;

    div_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.req_valid && bus.req_ready),
        .push_dat (push_req),
        .full     (full),
        .pop      (pop),
        .head_dat (head),
        .empty    (empty)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ld_dz     = 1'b0;
        ld_div    = 1'b0;
        ld_to     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.divisor == '0) begin
                        ld_dz     = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = START;
                    end
                end
            end
            START: state_nxt = BUSY;
            BUSY: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (bus.div_valid) begin
                    ld_div    = 1'b1;
                    state_nxt = HOLD;
                end else if (timer == T_LAST) begin
                    ld_to     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
            rsp_q       <= '0;
            rsp_r       <= '0;
            rsp_e       <= ERR_OK;
        end else begin
            state <= state_nxt;
            if (pop) begin
                op_dividend <= head.dividend;
                op_divisor  <= head.divisor;
            end
            if (state == START) begin
                timer <= '0;
            end else if (state == BUSY) begin
                timer <= timer + TW'(1);
            end
            if (ld_dz) begin
                rsp_q <= '1;
                rsp_r <= head.dividend;
                rsp_e <= ERR_DZ;
            end else if (ld_div) begin
                rsp_q <= bus.div_quotient;
                rsp_r <= bus.div_remainder;
                rsp_e <= ERR_OK;
            end else if (ld_to) begin
                rsp_q <= '0;
                rsp_r <= '0;
                rsp_e <= ERR_TO;
            end
        end
    end

    assign bus.div_start     = (state == START);
    assign bus.div_dividend  = op_dividend;
    assign bus.div_divisor   = op_divisor;
    assign bus.rsp_valid     = (state == HOLD);
    assign bus.rsp_quotient  = rsp_q;
    assign bus.rsp_remainder = rsp_r;
    assign bus.rsp_err       = rsp_e;
endmodule
